logic_serial_32_bit: RTL

- Area-reduced, multi-cycle 32-bit bitwise logic unit for the ALU path.
- Executes AND, OR, NOR or INV on two 32-bit operands, SLICE bits per cycle, LSB slice first.
- Uses a START/BUSY/DONE handshake so the control unit can stall on it like the multi-cycle arithmetic units.
- Result register holds the last completed result until the next accepted operation.

---
 rtl/logic_serial_32_bit.sv | 97 +++++++++
 1 files changed

// File: rtl/logic_serial_32_bit.sv
// Multi-cycle bitwise logic unit: AND/OR/NOR/INV over DATA_WIDTH bits, SLICE bits per
// cycle, LSB slice first, with a START/BUSY/DONE handshake and a held result register.
module logic_serial_32_bit #(
  parameter  int DATA_WIDTH = 32,
  parameter  int SLICE      = 4,
  localparam int NSLICE     = DATA_WIDTH / SLICE
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [1:0]            OPRN,
  input  logic [DATA_WIDTH-1:0] OP1,
  input  logic [DATA_WIDTH-1:0] OP2,
  output logic [DATA_WIDTH-1:0] R,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [1:0]            oprn_q;
  logic [DATA_WIDTH-1:0] op1_q, op2_q, shadow_q, r_q;
  logic                  busy_q, done_q;

  logic [SLICE-1:0]      a_sl, b_sl, res_sl;
  logic [DATA_WIDTH-1:0] shadow_d;
  logic                  last_sl;

  always_comb begin
    a_sl    = op1_q[cnt_q*SLICE +: SLICE];
    b_sl    = op2_q[cnt_q*SLICE +: SLICE];
    case (oprn_q)
      2'b00:   res_sl = a_sl & b_sl;
      2'b01:   res_sl = a_sl | b_sl;
      2'b10:   res_sl = ~(a_sl | b_sl);
      default: res_sl = ~a_sl;
    endcase
    shadow_d                         = shadow_q;
    shadow_d[cnt_q*SLICE +: SLICE]   = res_sl;
    last_sl = (cnt_q == CW'(NSLICE - 1));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      oprn_q   <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      shadow_q <= '0;
      r_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (START) begin
            op1_q   <= OP1;
            op2_q   <= OP2;
            oprn_q  <= OPRN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          // Final slice goes straight into R so R updates on the DONE-entry edge
          shadow_q <= shadow_d;
          cnt_q    <= cnt_q + 1'b1;
          if (last_sl) begin
            r_q     <= shadow_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign R    = r_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
